// File: rtl/crossy_game_if.sv
// Signal bundle between the crossing-game sequencer and the board/playfield side.
interface crossy_game_if;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       core_game_end;
    logic       core_reset;
    logic       move_left;
    logic       move_right;
    logic       move_up;
    logic [7:0] score;
    logic [1:0] state;

    modport master (
        input  btn_left, btn_right, btn_up, core_game_end,
        output core_reset, move_left, move_right, move_up, score, state
    );

    modport slave (
        output btn_left, btn_right, btn_up, core_game_end,
        input  core_reset, move_left, move_right, move_up, score, state
    );
endinterface

// File: rtl/crossy_game_ctrl.sv
// Button conditioning, IDLE/PLAY/DEAD session sequencing and score keeping for the crossing game.
// Optional macro AUTO_ADVANCE_EN adds a forced up-step after ADV_CYCLES of player inactivity.
module crossy_game_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ADV_CYCLES      = 200000000,
    parameter int unsigned HOLD_CYCLES     = 300000000
) (
    input logic           clk,
    input logic           reset,
    crossy_game_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DEAD = 2'd2;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || ADV_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
        $error("crossy_game_ctrl: cycle parameters must be at least 1");
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bit order everywhere: [0]=left, [1]=right, [2]=up.
    logic [2:0]        btn_raw;
    logic [2:0]        sync_p0, sync_p1;
    logic [2:0]        lvl_p2, lvl_p3;
    logic [DB_W-1:0]   db_cnt [3];
    logic [2:0]        evt;
    logic [1:0]        state_r;
    logic              core_reset_r;
    logic [2:0]        move_r;
    logic [7:0]        score_r;
    logic              up_vld_p1;
    logic [HOLD_W-1:0] hold_cnt;
`ifdef AUTO_ADVANCE_EN
    localparam int ADV_W = $clog2(ADV_CYCLES + 1);
    logic [ADV_W-1:0]  adv_cnt;
`endif

    assign btn_raw = {bus.btn_up, bus.btn_right, bus.btn_left};

    // Stage p0/p1: two-flop synchroniser; p2: debounced level; p3: delayed level for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            lvl_p2  <= '0;
            lvl_p3  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            lvl_p3  <= lvl_p2;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == lvl_p2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl_p2[i] <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign evt = lvl_p2 & ~lvl_p3;

    // Session FSM and command/score registers; a move_up arms a confirm two edges later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            core_reset_r <= 1'b0;
            move_r       <= '0;
            score_r      <= '0;
            up_vld_p1    <= 1'b0;
            hold_cnt     <= '0;
`ifdef AUTO_ADVANCE_EN
            adv_cnt      <= '0;
`endif
        end else begin
            core_reset_r <= 1'b0;
            move_r       <= '0;
            up_vld_p1    <= move_r[2];
            if (up_vld_p1 && !bus.core_game_end) score_r <= sat_inc(score_r);
            case (state_r)
                S_IDLE: begin
                    if (|evt) begin
                        core_reset_r <= 1'b1;
                        score_r      <= '0;
                        state_r      <= S_PLAY;
`ifdef AUTO_ADVANCE_EN
                        adv_cnt      <= '0;
`endif
                    end
                end
                S_PLAY: begin
                    if (bus.core_game_end) begin
                        state_r  <= S_DEAD;
                        hold_cnt <= '0;
                    end else begin
                        move_r <= evt[0] ? 3'b001 :
                                  evt[1] ? 3'b010 :
                                  evt[2] ? 3'b100 : 3'b000;
`ifdef AUTO_ADVANCE_EN
                        if (|evt) begin
                            adv_cnt <= '0;
                        end else if (adv_cnt == ADV_W'(ADV_CYCLES - 1)) begin
                            move_r  <= 3'b100;
                            adv_cnt <= '0;
                        end else begin
                            adv_cnt <= adv_cnt + 1'b1;
                        end
`endif
                    end
                end
                S_DEAD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) state_r <= S_IDLE;
                    else hold_cnt <= hold_cnt + 1'b1;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign bus.core_reset = core_reset_r;
    assign bus.move_left  = move_r[0];
    assign bus.move_right = move_r[1];
    assign bus.move_up    = move_r[2];
    assign bus.score      = score_r;
    assign bus.state      = state_r;
endmodule

// File: tb/tb_crossy_game_ctrl.sv
// Bench for crossy_game_ctrl: directed scenarios plus random button/game-end traffic against an edge-indexed reference model.
module tb_crossy_game_ctrl;
    localparam int DB = 4, ADV = 50, HOLD = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crossy_game_if bus ();
    crossy_game_ctrl #(.DEBOUNCE_CYCLES(DB), .ADV_CYCLES(ADV), .HOLD_CYCLES(HOLD))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;

    // Reference model: history of raw/synchronised samples indexed by edge, events as level rises.
    int         n_edge = 0;
    logic [2:0] rawlog[$];
    logic [2:0] slog[$];
    logic [2:0] lvl = '0, ev = '0;
    int         m_state = 0, m_score = 0;
    logic       m_core_reset = 1'b0;
    logic [2:0] m_move = '0;
    int         up_edges[$];
    int         anchor = 0, dead_at = 0;
    int         cnt_up = 0, cnt_left = 0, cnt_cr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [2:0] s, rise, raw_now;
        logic       all_diff, v;
        int         i, idx;
        n_edge++;
        raw_now = {bus.btn_up, bus.btn_right, bus.btn_left};
        if (reset) begin
            rawlog.delete(); slog.delete(); up_edges.delete();
            lvl = '0; ev = '0; m_state = 0; m_score = 0; m_core_reset = 1'b0; m_move = '0;
            return;
        end
        m_core_reset = 1'b0;
        m_move = '0;
        while (up_edges.size() > 0 && up_edges[0] < n_edge - 2) void'(up_edges.pop_front());
        if (up_edges.size() > 0 && up_edges[0] == n_edge - 2 && !bus.core_game_end)
            m_score = (m_score == 255) ? 255 : m_score + 1;
        case (m_state)
            0: if (ev != 0) begin
                m_core_reset = 1'b1; m_score = 0; m_state = 1; anchor = n_edge;
            end
            1: if (bus.core_game_end) begin
                m_state = 2; dead_at = n_edge;
            end else if (ev != 0) begin
                m_move = ev[0] ? 3'b001 : (ev[1] ? 3'b010 : 3'b100);
                anchor = n_edge;
                if (m_move[2]) up_edges.push_back(n_edge);
            end else begin
`ifdef AUTO_ADVANCE_EN
                if (n_edge - anchor == ADV) begin
                    m_move = 3'b100; anchor = n_edge; up_edges.push_back(n_edge);
                end
`endif
            end
            default: if (n_edge - dead_at == HOLD) m_state = 0;
        endcase
        // Synchronised sample at this edge is the raw value two edges back; flip when DB in a row differ.
        i = rawlog.size();
        s = (i >= 2) ? rawlog[i-2] : 3'b000;
        slog.push_back(s);
        rawlog.push_back(raw_now);
        rise = '0;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) begin
                idx = slog.size() - 1 - k;
                v = (idx >= 0) ? slog[idx][b] : 1'b0;
                if (v == lvl[b]) all_diff = 1'b0;
            end
            if (all_diff) begin
                rise[b] = ~lvl[b];
                lvl[b]  = ~lvl[b];
            end
        end
        ev = rise;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("state", bus.state, m_state);
            chk("score", bus.score, m_score);
            chk("core_reset", bus.core_reset, m_core_reset);
            chk("moves", {bus.move_up, bus.move_right, bus.move_left}, m_move);
            cnt_up   += bus.move_up;
            cnt_left += bus.move_left;
            cnt_cr   += bus.core_reset;
        end
    endtask

    task automatic set_btn(input logic [2:0] v);
        bus.btn_left  = v[0];
        bus.btn_right = v[1];
        bus.btn_up    = v[2];
    endtask

    task automatic press(input logic [2:0] v);
        set_btn(v); cyc(8);
        set_btn(3'b000); cyc(8);
    endtask

    task automatic clear_counts();
        cnt_up = 0; cnt_left = 0; cnt_cr = 0;
    endtask

    initial begin
        int seen, dead_len;
        logic [2:0] rb;
        reset = 1'b1;
        set_btn(3'b000);
        bus.core_game_end = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        chk("reset_state", bus.state, 0);

        // Start a session: the starting press is consumed.
        clear_counts();
        set_btn(3'b100); cyc(10);
        set_btn(3'b000); cyc(8);
        chk("start_state", bus.state, 1);
        chk("start_core_reset_pulses", cnt_cr, 1);
        chk("start_no_move_up", cnt_up, 0);
        chk("start_score", bus.score, 0);

        // Bouncing up press yields exactly one move_up.
        clear_counts();
        set_btn(3'b100); cyc(1);
        set_btn(3'b000); cyc(1);
        set_btn(3'b100); cyc(10);
        set_btn(3'b000); cyc(8);
        chk("bounce_up_pulses", cnt_up, 1);

        // Simultaneous left and up: left wins, up dropped.
        clear_counts();
        press(3'b101);
        chk("prio_left_pulses", cnt_left, 1);
        chk("prio_up_pulses", cnt_up, 0);

        press(3'b100);
        press(3'b100);
        chk("score_three", bus.score, 3);

        // Fourth up with game end raised one cycle after the pulse.
        set_btn(3'b100);
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            cyc(1);
            if (bus.move_up) seen = 1;
        end
        chk("fourth_up_seen", seen, 1);
        cyc(1);
        bus.core_game_end = 1'b1;
        set_btn(3'b000);
        dead_len = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1);
            if (bus.state == 2'd2) dead_len++;
            else if (dead_len > 0) break;
        end
        chk("dead_score_held", bus.score, 3);
        chk("dead_length", dead_len, HOLD);
        cyc(5);
        chk("idle_ignores_game_end", bus.state, 0);
        bus.core_game_end = 1'b0;
        cyc(3);

        // Random traffic against the model.
        rb = '0;
        for (int k = 0; k < 2000; k++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 9) == 0) rb[b] = ~rb[b];
            set_btn(rb);
            bus.core_game_end = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        reset = 1'b0;
        bus.core_game_end = 1'b0;
        set_btn(3'b000);
        cyc(10);

        // Reset while DEAD with score 5.
        reset = 1'b1; cyc(1);
        reset = 1'b0; cyc(1);
        press(3'b100);
        for (int k = 0; k < 5; k++) press(3'b100);
        chk("score_five", bus.score, 5);
        bus.core_game_end = 1'b1;
        cyc(3);
        chk("dead_before_reset", bus.state, 2);
        reset = 1'b1;
        cyc(1);
        chk("reset_dead_state", bus.state, 0);
        chk("reset_dead_score", bus.score, 0);
        chk("reset_dead_outputs", {bus.core_reset, bus.move_up, bus.move_right, bus.move_left}, 0);
        reset = 1'b0;
        bus.core_game_end = 1'b0;
        cyc(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
